mfp_multi_digit_seven_segment_display: RTL and testbench

Parametrised, time-multiplexed N-digit hex seven-segment driver for external common-anode/cathode modules on GPIO headers. It supersedes per-digit static decoders.
- Scans one digit per slot.
- Latches display data once per frame, so digits never tear mid-frame.
- Adds per-digit blanking, decimal points, 16-level PWM brightness and built-in anti-ghosting dead time.
- Sits in the board top, fed from the mfp_system 7-segment GPIO word.

---
 rtl/mfp_7seg_pkg.sv | 26 ++
 rtl/mfp_7seg_hex_decoder.sv | 33 +++
 rtl/mfp_multi_digit_seven_segment_display.sv | 112 +++++++++++
 tb/tb_mfp_multi_digit_seven_segment_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mfp_7seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-high hex
// segment patterns {g,f,e,d,c,b,a} and PWM phase width.
package mfp_7seg_pkg;

  localparam int PWM_PHASE_W = 4;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/mfp_7seg_hex_decoder.sv
// Combinational hex nibble -> active-high segment pattern; output polarity is
// applied by the parent.
module mfp_7seg_hex_decoder
  import mfp_7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_OFF;
    case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_A;
      4'hB: segs = SEG_B;
      4'hC: segs = SEG_C;
      4'hD: segs = SEG_D;
      4'hE: segs = SEG_E;
      4'hF: segs = SEG_F;
      default: segs = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mfp_multi_digit_seven_segment_display.sv
// Time-multiplexed N-digit hex display driver with per-frame shadow latch,
// PWM brightness and dead time. MFP_7SEG_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
module mfp_multi_digit_seven_segment_display
  import mfp_7seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV_W     = 16,  // must be >= PWM_PHASE_W
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            brightness,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_MASK  = {DIGITS{AN_ACTIVE_LOW}};

  logic [SCAN_DIV_W-1:0]    cnt;
  logic [IDX_W-1:0]         idx;
  logic                     first_frame;
  logic [DIGITS-1:0][3:0]   num_in;
  logic [DIGITS-1:0][3:0]   shadow_num;
  logic [DIGITS-1:0]        shadow_en;
  logic [DIGITS-1:0]        shadow_dp;
  logic [DIGITS-1:0]        shadow_blank;
  logic [DIGITS-1:0]        lz_mask;
  logic [DIGITS-1:0][6:0]   dec_segs;
  logic [PWM_PHASE_W-1:0]   phase;
  logic                     cnt_wrap;
  logic                     frame_wrap;
  logic                     latch;
  logic                     digit_on;
  logic [DIGITS-1:0]        sel_onehot;

  assign num_in = number;

`ifdef MFP_7SEG_LEADING_ZERO_BLANK_EN
  logic lz_stop;

  // Walk down from the top digit; suppression ends at the first digit that
  // carries information (nonzero value or a visible decimal point).
  always_comb begin
    lz_mask = '0;
    lz_stop = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (num_in[i] != 4'h0 || (digit_en[i] && dp[i])) lz_stop = 1'b1;
      else if (!lz_stop) lz_mask[i] = 1'b1;
    end
  end
`else
  assign lz_mask = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    mfp_7seg_hex_decoder u_dec (
      .nibble (shadow_num[i]),
      .segs   (dec_segs[i])
    );
  end

  assign phase      = cnt[SCAN_DIV_W-1 -: PWM_PHASE_W];
  assign cnt_wrap   = &cnt;
  assign frame_wrap = cnt_wrap && (idx == IDX_LAST);
  assign latch      = first_frame || frame_wrap;
  assign sel_onehot = DIGITS'(1) << idx;

  // Phase 0 of every slot stays dark so the previous digit's segments cannot
  // ghost onto the next anode.
  assign digit_on = shadow_en[idx] && !shadow_blank[idx] &&
                    (phase != '0) && (phase <= brightness);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      first_frame    <= 1'b1;
      shadow_num     <= '0;
      shadow_en      <= '0;
      shadow_dp      <= '0;
      shadow_blank   <= '0;
      frame_start    <= 1'b0;
      seven_segments <= SEG_OFF ^ SEG_MASK;
      dot            <= SEG_ACTIVE_LOW;
      anodes         <= AN_MASK;
    end else begin
      cnt         <= cnt + SCAN_DIV_W'(1);
      first_frame <= 1'b0;
      frame_start <= latch;
      if (cnt_wrap) idx <= frame_wrap ? '0 : idx + IDX_W'(1);
      if (latch) begin
        shadow_num   <= num_in;
        shadow_en    <= digit_en;
        shadow_dp    <= dp;
        shadow_blank <= lz_mask;
      end
      seven_segments <= (digit_on ? dec_segs[idx] : SEG_OFF) ^ SEG_MASK;
      dot            <= (digit_on && shadow_dp[idx]) ^ SEG_ACTIVE_LOW;
      anodes         <= (digit_on ? sel_onehot : '0) ^ AN_MASK;
    end
  end

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_display.sv
// Scoreboard bench: per-cycle expectations from a timeline model of the scan,
// compared by a negedge monitor against the registered display outputs.
module tb_mfp_multi_digit_seven_segment_display;

  localparam int DIGITS    = 4;
  localparam int SLOT      = 64;
  localparam int PHASE_LEN = SLOT / 16;
  localparam int FRAME     = SLOT * DIGITS;

  localparam logic [6:0] HEX_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] number;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  brightness;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame_start;

  mfp_multi_digit_seven_segment_display #(
    .DIGITS         (DIGITS),
    .SCAN_DIV_W     (6),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .number         (number),
    .digit_en       (digit_en),
    .dp             (dp),
    .brightness     (brightness),
    .seven_segments (seven_segments),
    .dot            (dot),
    .anodes         (anodes),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dt;
    logic [3:0] an;
    logic       fs;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  // Model: what the display holds for the current frame, and how many clock
  // edges have elapsed since reset was released.
  int    edges = 0;
  int    m_num  [DIGITS];
  bit    m_show [DIGITS];
  bit    m_dp   [DIGITS];

  task automatic latch_model();
    int top;
    top = 0;
    for (int d = 0; d < DIGITS; d++) begin
      m_num[d]  = int'((number >> (4 * d)) & 16'hF);
      m_dp[d]   = dp[d];
      m_show[d] = digit_en[d];
      if (m_num[d] != 0 || (digit_en[d] && dp[d])) top = d;
    end
`ifdef MFP_7SEG_LEADING_ZERO_BLANK_EN
    for (int d = top + 1; d < DIGITS; d++) m_show[d] = 1'b0;
`endif
  endtask

  // Predict the outputs after the next rising edge, queue them, advance.
  task automatic tick();
    resp_t e;
    int    pos;
    int    d;
    int    ph;
    bit    on;
    bit    fs;
    if (rst) begin
      edges = 0;
      e.seg = 7'h7F;
      e.dt  = 1'b1;
      e.an  = 4'hF;
      e.fs  = 1'b0;
    end else begin
      edges++;
      pos = edges - 1;
      d   = (pos / SLOT) % DIGITS;
      ph  = (pos % SLOT) / PHASE_LEN;
      on  = m_show[d] && ph != 0 && ph <= int'(brightness);
      fs  = (edges == 1) || (edges % FRAME == 0);
      e.seg = on ? ~HEX_ON[m_num[d]] : 7'h7F;
      e.dt  = on ? !m_dp[d] : 1'b1;
      e.an  = on ? ~(4'b0001 << d) : 4'hF;
      e.fs  = fs;
      if (fs) latch_model();
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    resp_t e;
    resp_t a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {seven_segments, dot, anodes, frame_start};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scan @cycle %0d: got seg=%h dot=%b an=%b fs=%b, want seg=%h dot=%b an=%b fs=%b",
                 cyc, a.seg, a.dt, a.an, a.fs, e.seg, e.dt, e.an, e.fs);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    number     = 16'h0;
    digit_en   = 4'h0;
    dp         = 4'h0;
    brightness = 4'h0;
    run(3);

    rst        = 1'b0;
    number     = 16'h1234;
    digit_en   = 4'hF;
    brightness = 4'd15;
    run(2 * FRAME);

    brightness = 4'd0;
    run(FRAME);
    brightness = 4'd4;
    run(FRAME);

    // Change the value halfway through digit 1's slot: must not tear.
    brightness = 4'd15;
    run(SLOT + SLOT / 2);
    number = 16'hABCD;
    run(2 * FRAME);

    digit_en = 4'b0101;
    dp       = 4'b0001;
    run(2 * FRAME);

    digit_en = 4'hF;
    dp       = 4'h0;
    number   = 16'h0007;
    run(2 * FRAME);
    number   = 16'h0000;
    run(2 * FRAME);
    number   = 16'h0300;
    dp       = 4'b1000;
    run(2 * FRAME);

    // Reset in the middle of a scan, then resume.
    run(SLOT + 37);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(FRAME + 10);

    repeat (30) begin
      for (int d = 0; d < DIGITS; d++)
        number[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) digit_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) dp = 4'($urandom_range(0, 15));
      brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      run($urandom_range(1, 400));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
